// File: rtl/gc_input_pkg.sv
// Shared constants, repeat-FSM states and the stick hysteresis helper for the
// gamecube input event block.
package gc_input_pkg;
  localparam int NUM_BTN = 12;
  localparam int NUM_DIR = 4;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_X      = 2;
  localparam int BTN_Y      = 3;
  localparam int BTN_START  = 4;
  localparam int BTN_L      = 5;
  localparam int BTN_R      = 6;
  localparam int BTN_Z      = 7;
  localparam int BTN_DUP    = 8;
  localparam int BTN_DDOWN  = 9;
  localparam int BTN_DRIGHT = 10;
  localparam int BTN_DLEFT  = 11;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_RIGHT = 2;
  localparam int DIR_LEFT  = 3;

  localparam logic [7:0] JOY_CENTRE = 8'd128;

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_e;

  // One stick axis: st_q/return are {neg,pos}; opposite directions never coexist.
  function automatic logic [1:0] axis_next(input logic [7:0] joy, input logic [1:0] st_q,
                                           input int dead_on, input int dead_off);
    logic signed [8:0] off, on_t, off_t;
    logic pos, neg;
    off   = $signed({1'b0, joy} - 9'd128);
    on_t  = $signed(9'(dead_on));
    off_t = $signed(9'(dead_off));
    pos = st_q[0] ? (off >= off_t) : (off >= on_t);
    neg = st_q[1] ? (off <= -off_t) : (off <= -on_t);
    return (pos && neg) ? 2'b00 : {neg, pos};
  endfunction
endpackage

// File: rtl/gc_autorepeat.sv
// Menu-style auto-repeat for one direction: first step on press, then after
// REPEAT_DELAY frames, then every REPEAT_RATE frames. Advances only on commit.
module gc_autorepeat
  import gc_input_pkg::*;
#(
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic held,
  output logic step
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE - 1);

  rpt_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          step_q, step_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    if (commit) begin
      if (!held) begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            step_d  = 1'b1;
            cnt_d   = DELAY_LD;
            state_d = RPT_DELAY;
          end
          RPT_DELAY: begin
            if (cnt_q == '0) begin
              step_d  = 1'b1;
              cnt_d   = RATE_LD;
              state_d = RPT_REPEAT;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          RPT_REPEAT: begin
            if (cnt_q == '0) begin
              step_d = 1'b1;
              cnt_d  = RATE_LD;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          default: state_d = RPT_IDLE;
        endcase
      end
    end
  end

  assign step = step_q;
endmodule

// File: rtl/gc_input_events.sv
// Frame-synchronous game inputs from the gamecube decoder: staged samples are
// committed on frame_tick into held levels, edge pulses, directions and repeats.
module gc_input_events
  import gc_input_pkg::*;
#(
  parameter int DEAD_ON      = 40,
  parameter int DEAD_OFF     = 24,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 6,
  parameter int STALE_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [NUM_BTN-1:0]   buttons,
  input  logic [7:0]           joy_x,
  input  logic [7:0]           joy_y,
  input  logic                 frame_tick,
  output logic [NUM_BTN-1:0]   btn_held,
  output logic [NUM_BTN-1:0]   btn_press,
  output logic [NUM_BTN-1:0]   btn_release,
  output logic [NUM_DIR-1:0]   dir_held,
  output logic [NUM_DIR-1:0]   dir_step,
  output logic                 link_lost
);
  localparam int SW = $clog2(STALE_FRAMES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);

  logic [NUM_BTN-1:0] stg_btn_q, stg_btn_d, held_q, held_d, press_q, press_d, rel_q, rel_d;
  logic [7:0]         stg_x_q, stg_x_d, stg_y_q, stg_y_d;
  logic [NUM_DIR-1:0] stick_q, stick_d, dir_q, dir_d;
  logic [SW-1:0]      stale_q, stale_d, stale_inc;
  logic               seen_q, seen_d, lost_q, lost_d;
  logic               idle_tick, tick_lost, force_rel;
  logic [NUM_BTN-1:0] eff_btn;
  logic [7:0]         eff_x, eff_y;
  logic [1:0]         ax_x, ax_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_btn_q <= '0;
      stg_x_q   <= '0;
      stg_y_q   <= '0;
      held_q    <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      stick_q   <= '0;
      dir_q     <= '0;
      stale_q   <= '0;
      seen_q    <= 1'b0;
      lost_q    <= 1'b1;
    end else begin
      stg_btn_q <= stg_btn_d;
      stg_x_q   <= stg_x_d;
      stg_y_q   <= stg_y_d;
      held_q    <= held_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      stick_q   <= stick_d;
      dir_q     <= dir_d;
      stale_q   <= stale_d;
      seen_q    <= seen_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    stg_btn_d = stg_btn_q;
    stg_x_d   = stg_x_q;
    stg_y_d   = stg_y_q;
    held_d    = held_q;
    press_d   = '0;
    rel_d     = '0;
    stick_d   = stick_q;
    dir_d     = dir_q;
    stale_d   = stale_q;
    seen_d    = seen_q | sample_valid;
    lost_d    = lost_q;
    stale_inc = (stale_q == STALE_MAX) ? stale_q : stale_q + 1'b1;
    // A frame that is about to become stale already commits released inputs.
    idle_tick = frame_tick && !seen_q && !sample_valid;
    tick_lost = idle_tick && (stale_inc == STALE_MAX);
    force_rel = lost_q | tick_lost;
    eff_btn   = force_rel ? '0 : stg_btn_q;
    eff_x     = force_rel ? JOY_CENTRE : stg_x_q;
    eff_y     = force_rel ? JOY_CENTRE : stg_y_q;
    ax_x      = axis_next(eff_x, {stick_q[DIR_LEFT], stick_q[DIR_RIGHT]}, DEAD_ON, DEAD_OFF);
    ax_y      = axis_next(eff_y, {stick_q[DIR_DOWN], stick_q[DIR_UP]}, DEAD_ON, DEAD_OFF);
    if (frame_tick) begin
      seen_d = 1'b0;
      if (idle_tick) stale_d = stale_inc;
      lost_d   = force_rel;
      held_d   = eff_btn;
      press_d  = eff_btn & ~held_q;
      rel_d    = ~eff_btn & held_q;
      stick_d[DIR_RIGHT] = ax_x[0];
      stick_d[DIR_LEFT]  = ax_x[1];
      stick_d[DIR_UP]    = ax_y[0];
      stick_d[DIR_DOWN]  = ax_y[1];
      dir_d[DIR_UP]      = eff_btn[BTN_DUP]    | ax_y[0];
      dir_d[DIR_DOWN]    = eff_btn[BTN_DDOWN]  | ax_y[1];
      dir_d[DIR_RIGHT]   = eff_btn[BTN_DRIGHT] | ax_x[0];
      dir_d[DIR_LEFT]    = eff_btn[BTN_DLEFT]  | ax_x[1];
    end
    // A fresh sample is staged after the commit has used the old contents.
    if (sample_valid) begin
      stg_btn_d = buttons;
      stg_x_d   = joy_x;
      stg_y_d   = joy_y;
      stale_d   = '0;
      lost_d    = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_DIR; g++) begin : g_rpt
    gc_autorepeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rpt (
      .clk    (clk),
      .reset  (reset),
      .commit (frame_tick),
      .held   (dir_d[g]),
      .step   (dir_step[g])
    );
  end

  assign btn_held    = held_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign dir_held    = dir_q;
  assign link_lost   = lost_q;
endmodule

// File: doc/gc_input_events.md
Name: gc_input_events

Overview:
Sits directly downstream of the gamecube controller decoder. It converts raw, asynchronously refreshed button and stick fields into frame-synchronous game inputs for the arcade logic:
- held levels
- one-frame press/release pulses
- stick-to-direction conversion with hysteresis
- menu-style auto-repeat steps
- link-loss detection
All outputs update once per VGA frame, so game logic sees a stable snapshot for the whole frame.

Parameters:
DEAD_ON, 40, stick offset magnitude (from centre 128) at or above which a stick direction asserts
DEAD_OFF, 24, offset magnitude below which an asserted stick direction clears (hysteresis; must be < DEAD_ON)
REPEAT_DELAY, 20, frames from the first step until the first auto-repeat step
REPEAT_RATE, 6, frames between subsequent auto-repeat steps
STALE_FRAMES, 8, frames without sample_valid before link_lost asserts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sample_valid  in  1  one-cycle pulse: buttons/joy_x/joy_y hold a fresh poll result
buttons  in  12  {D_LEFT,D_RIGHT,D_DOWN,D_UP,Z,R,L,START,Y,X,B,A}, bit0=A
joy_x  in  8  main stick X, unsigned, 128 = centre, larger = right
joy_y  in  8  main stick Y, unsigned, 128 = centre, larger = up
frame_tick  in  1  one-cycle pulse per video frame (vsync start)
btn_held  out  12  committed button levels
btn_press  out  12  one-cycle pulse per bit on 0->1 of btn_held
btn_release  out  12  one-cycle pulse per bit on 1->0 of btn_held
dir_held  out  4  {left,right,down,up}: D-pad OR stick direction
dir_step  out  4  auto-repeat step pulses per direction
link_lost  out  1  high while no fresh sample has arrived within STALE_FRAMES frames

Behaviour:
- Reset (async assert, sync release): all outputs 0 except link_lost=1. Staging registers cleared. Stale counter = 0. Every repeat FSM in IDLE.
- Staging: on sample_valid, capture buttons/joy_x/joy_y into staging registers and clear link_lost/stale counter in the next cycle.
- Commit: on frame_tick at cycle T, every output reflects the commit at T+1. Press/release/step pulses are high for exactly cycle T+1; held outputs stay stable until the next commit.
- Simultaneous sample_valid and frame_tick: the commit uses the old staging contents. The new sample is staged and becomes visible at the next frame.
- Stale detection:
  - Each frame_tick with no sample_valid since the previous frame_tick increments the stale counter (saturating).
  - When the counter reaches STALE_FRAMES, link_lost=1.
  - While link_lost=1, effective inputs are forced to all-released and centred. Held buttons therefore produce release pulses at the next commit; no spurious presses occur.
- Stick conversion, per axis:
  - offset = {1'b0,joy} - 9'd128, 9-bit signed.
  - Right sets when offset >= DEAD_ON and clears when offset < DEAD_OFF. Left is the mirror: sets at offset <= -DEAD_ON, clears at offset > -DEAD_OFF.
  - Up/down use the same rules on joy_y.
  - Opposite directions on one axis are never both set. If both would set, the axis state resolves to neither.
  - Extremes: joy=0 gives offset -128 and joy=255 gives +127, with no overflow.
- dir_held[d] = committed D-pad bit OR stick state.
  - D-pad up+down pressed together: both bits held; no suppression for the D-pad.
- Auto-repeat FSM, one per direction, advancing only on commit:
  - IDLE: dir_held rises -> step pulse, load cnt=REPEAT_DELAY-1, go to DELAY.
  - DELAY: cnt==0 -> step pulse, load cnt=REPEAT_RATE-1, go to REPEAT; otherwise cnt--.
  - REPEAT: cnt==0 -> step pulse, reload cnt=REPEAT_RATE-1; otherwise cnt--.
  - From any state, dir_held low -> IDLE with no pulse. A release and a re-press across two commits restarts with a fresh step.
  - Counter width = $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
- Reset mid-operation: all state is cleared immediately; no pulses are emitted during or on release of reset.

Decomposition:
- Package gc_input_pkg holds:
  - button index constants (BTN_A..BTN_DLEFT)
  - direction indices (DIR_UP=0, DIR_DOWN=1, DIR_RIGHT=2, DIR_LEFT=3)
  - JOY_CENTRE=128
  - the repeat FSM state enum
- Natural sub-module: gc_autorepeat (one direction: held in, commit strobe in, step out), instantiated 4 times.

Test Plan:
- Reset released, no sample_valid, 9 frame_ticks -> link_lost stays 1, all outputs 0; one sample_valid -> link_lost 0 on the next cycle.
- Stage buttons=12'h001, frame_tick -> btn_held[0]=1 and btn_press[0]=1 for exactly one cycle; stage 12'h000, frame_tick -> btn_release[0] pulses once.
- joy_x sweeps 128->168 (right sets), ->153 (stays set), ->151 (clears); joy_x=88 sets left. Committed frame-by-frame, check dir_held[2]/[3].
- Hold D_UP for 40 frames with REPEAT_DELAY=20, REPEAT_RATE=6 -> dir_step[0] pulses at frames 0, 20, 26, 32, 38; release -> no further pulses.
- Hold A, then stop sample_valid for 8 frames -> link_lost=1 and btn_release[0] pulses at that commit; sample_valid and frame_tick in the same cycle -> the commit shows the old staging value.
- Assert reset while in REPEAT with buttons held -> all outputs 0 immediately, link_lost=1, no pulse after release.
